// File: rtl/decode_stage_if.sv
// Fetch-to-decode link: fetched PC/instruction, execute's flush request,
// and the combinational stall back to fetch.
interface decode_stage_if;
  logic [31:0] pc_in;
  logic [31:0] insn_in;
  logic        do_branch;
  logic        stall;

  modport master (output pc_in, output insn_in, output do_branch, input stall);
  modport slave  (input pc_in, input insn_in, input do_branch, output stall);
endinterface

// File: rtl/decode_stage.sv
// Decode stage: field split, immediate extension, control generation and the D/E
// register, with load-use stall/replay through a one-entry hold buffer.
module decode_stage #(
  parameter logic [31:0] NOP_PC = 32'h0000_0000
) (
  input  logic          clock,
  input  logic          reset,
  decode_stage_if.slave fe,
  output logic          valid_out,
  output logic [31:0]   pc_out,
  output logic [5:0]    opcode_out,
  output logic [4:0]    rs_out,
  output logic [4:0]    rt_out,
  output logic [4:0]    dest_out,
  output logic [4:0]    shamt_out,
  output logic [5:0]    funct_out,
  output logic [31:0]   imm_out,
  output logic [25:0]   target_out,
  output logic          reg_write,
  output logic          mem_read,
  output logic          mem_write,
  output logic          alu_src,
  output logic          branch,
  output logic          jump,
  output logic          illegal
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24;
  localparam logic [5:0] F_OR = 6'h25, F_SLT = 6'h2A;

  logic        r_hold_valid;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_insn;

  logic [31:0] w_pc;
  logic [31:0] w_insn;
  logic        w_real;
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic        w_rw;
  logic        w_mr;
  logic        w_mw;
  logic        w_as;
  logic        w_br;
  logic        w_jp;
  logic        w_il;
  logic        w_zext;
  logic        w_uses_rs;
  logic        w_uses_rt;
  logic [4:0]  w_dest;
  logic [31:0] w_imm;
  logic        w_hazard;

  // The hold buffer takes precedence over fetch; fetch sends NOP_PC while stalled.
  assign w_pc    = r_hold_valid ? r_hold_pc   : fe.pc_in;
  assign w_insn  = r_hold_valid ? r_hold_insn : fe.insn_in;
  assign w_real  = r_hold_valid | (fe.pc_in != NOP_PC);
  assign w_op    = w_insn[31:26];
  assign w_funct = w_insn[5:0];
  assign w_rs    = w_insn[25:21];
  assign w_rt    = w_insn[20:16];
  assign w_rd    = w_insn[15:11];
  assign w_imm   = w_zext ? {16'h0000, w_insn[15:0]} : {{16{w_insn[15]}}, w_insn[15:0]};

  // Opcode/funct decode into control, destination and source-use flags.
  always_comb begin
    w_rw = 1'b0; w_mr = 1'b0; w_mw = 1'b0; w_as = 1'b0;
    w_br = 1'b0; w_jp = 1'b0; w_il = 1'b0; w_zext = 1'b0;
    w_uses_rs = 1'b1; w_uses_rt = 1'b0; w_dest = 5'd0;
    case (w_op)
      OP_RTYPE: begin
        w_uses_rt = 1'b1;
        case (w_funct)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLT: begin
            w_rw = 1'b1; w_dest = w_rd;
          end
          F_SLL, F_SRL: begin
            w_rw = 1'b1; w_dest = w_rd; w_uses_rs = 1'b0;
          end
          F_JR:    begin w_jp = 1'b1; w_dest = w_rd; end
          default: w_il = 1'b1;
        endcase
      end
      OP_ADDIU, OP_SLTI: begin w_rw = 1'b1; w_as = 1'b1; w_dest = w_rt; end
      OP_ANDI, OP_ORI:   begin w_rw = 1'b1; w_as = 1'b1; w_dest = w_rt; w_zext = 1'b1; end
      OP_LUI:  begin w_rw = 1'b1; w_as = 1'b1; w_dest = w_rt; w_uses_rs = 1'b0; end
      OP_LW:   begin w_rw = 1'b1; w_mr = 1'b1; w_as = 1'b1; w_dest = w_rt; end
      OP_SW:   begin w_mw = 1'b1; w_as = 1'b1; w_uses_rt = 1'b1; end
      OP_BEQ, OP_BNE: begin w_br = 1'b1; w_uses_rt = 1'b1; end
      OP_J:    begin w_jp = 1'b1; w_uses_rs = 1'b0; end
      OP_JAL:  begin w_jp = 1'b1; w_rw = 1'b1; w_dest = 5'd31; w_uses_rs = 1'b0; end
      default: w_il = 1'b1;
    endcase
  end

  // Only a fresh fetch can be stalled; a replay's producer is always a bubble.
  assign w_hazard = valid_out & mem_read & (dest_out != 5'd0) & w_real & ~r_hold_valid
                  & ((w_uses_rs & (w_rs == dest_out)) | (w_uses_rt & (w_rt == dest_out)))
                  & ~fe.do_branch;
  assign fe.stall = w_hazard;

  // D/E pipeline register and hold buffer, flush over stall over issue.
  always_ff @(posedge clock) begin
    if (reset || fe.do_branch || w_hazard || !w_real) begin
      valid_out  <= 1'b0;
      pc_out     <= 32'h0000_0000;
      opcode_out <= 6'h00;
      rs_out     <= 5'd0;
      rt_out     <= 5'd0;
      dest_out   <= 5'd0;
      shamt_out  <= 5'd0;
      funct_out  <= 6'h00;
      imm_out    <= 32'h0000_0000;
      target_out <= 26'h000_0000;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      alu_src    <= 1'b0;
      branch     <= 1'b0;
      jump       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      valid_out  <= 1'b1;
      pc_out     <= w_pc;
      opcode_out <= w_op;
      rs_out     <= w_rs;
      rt_out     <= w_rt;
      dest_out   <= w_dest;
      shamt_out  <= w_insn[10:6];
      funct_out  <= w_funct;
      imm_out    <= w_imm;
      target_out <= w_insn[25:0];
      reg_write  <= w_rw & (w_dest != 5'd0);
      mem_read   <= w_mr;
      mem_write  <= w_mw;
      alu_src    <= w_as;
      branch     <= w_br;
      jump       <= w_jp;
      illegal    <= w_il;
    end
    if (reset) begin
      r_hold_valid <= 1'b0;
      r_hold_pc    <= 32'h0000_0000;
      r_hold_insn  <= 32'h0000_0000;
    end else if (!fe.do_branch && w_hazard) begin
      r_hold_valid <= 1'b1;
      r_hold_pc    <= fe.pc_in;
      r_hold_insn  <= fe.insn_in;
    end else begin
      r_hold_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: each stimulus cycle queues the expected
// D/E contents; a monitor pops and compares one entry per presented output cycle.
module tb_decode_stage;
  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [6:0]  ctrl; // {reg_write, mem_read, mem_write, alu_src, branch, jump, illegal}
  } exp_t;

  localparam logic [31:0] A      = 32'h8002_0000;
  localparam logic [31:0] LW3    = 32'h8C83_0000;
  localparam logic [31:0] LW4    = 32'h8C64_0000;
  localparam logic [31:0] LW0    = 32'h8C80_0000;
  localparam logic [31:0] ADD5   = 32'h0066_2820;
  localparam logic [31:0] ADD5B  = 32'h0086_2820;
  localparam logic [31:0] ADDZ   = 32'h0000_2820;
  localparam logic [31:0] ADDIU5 = 32'h2442_0005;
  localparam logic [31:0] ADDIUM = 32'h2442_FFFF;
  localparam logic [31:0] ANDI   = 32'h3042_FFFF;
  localparam logic [31:0] JAL    = 32'h0C00_0010;
  localparam logic [31:0] SW3    = 32'hACE3_0000;
  localparam logic [31:0] LUI3   = 32'h3C03_0001;
  localparam logic [31:0] ILL    = 32'hFC00_0000;
  localparam exp_t        BUB    = '0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic        valid_out, reg_write, mem_read, mem_write, alu_src, branch, jump, illegal;
  logic [31:0] pc_out, imm_out;
  logic [5:0]  opcode_out, funct_out;
  logic [4:0]  rs_out, rt_out, dest_out, shamt_out;
  logic [25:0] target_out;

  int   checks = 0;
  int   failures = 0;
  int   pend = 0;
  int   mon_idx = 0;
  exp_t exp_q[$];

  decode_stage_if ifc();

  decode_stage dut (
    .clock(clock), .reset(reset), .fe(ifc),
    .valid_out(valid_out), .pc_out(pc_out), .opcode_out(opcode_out),
    .rs_out(rs_out), .rt_out(rt_out), .dest_out(dest_out), .shamt_out(shamt_out),
    .funct_out(funct_out), .imm_out(imm_out), .target_out(target_out),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .branch(branch), .jump(jump), .illegal(illegal)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [4:0] dest,
                              input logic [31:0] imm, input logic [6:0] ctrl);
    exp_t e;
    e.v = v; e.pc = pc; e.dest = dest; e.imm = imm; e.ctrl = ctrl;
    return e;
  endfunction

  // One input cycle: drive after the edge, check the combinational stall, queue the D/E result.
  task automatic step(input logic rst, input logic [31:0] pc, input logic [31:0] insn,
                      input logic br, input logic exp_stall, input exp_t e, input string nm);
    @(posedge clock);
    #1;
    reset = rst; ifc.pc_in = pc; ifc.insn_in = insn; ifc.do_branch = br;
    #1;
    checks++;
    if (ifc.stall !== exp_stall) begin
      failures++;
      $display("FAIL stall[%s] got=%0b exp=%0b", nm, ifc.stall, exp_stall);
    end
    exp_q.push_back(e);
  endtask

  always @(posedge clock) pend = exp_q.size();

  // Monitor: one expected entry per output cycle, compared away from the active edge.
  always @(negedge clock) begin
    exp_t e, g;
    if (pend > 0) begin
      e = exp_q.pop_front();
      g = mk(valid_out, pc_out, dest_out, imm_out,
             {reg_write, mem_read, mem_write, alu_src, branch, jump, illegal});
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL de_out[%0d] got v=%0b pc=%h dest=%0d imm=%h ctrl=%b exp v=%0b pc=%h dest=%0d imm=%h ctrl=%b",
                 mon_idx, g.v, g.pc, g.dest, g.imm, g.ctrl, e.v, e.pc, e.dest, e.imm, e.ctrl);
      end
      mon_idx++;
      pend = 0;
    end
  end

  initial begin
    ifc.pc_in = 32'h0; ifc.insn_in = 32'h0; ifc.do_branch = 1'b0;
    repeat (2) @(posedge clock);
    // Reset, then a reset arriving while an instruction is held
    step(1'b1, 32'h0,  32'h0,  1'b0, 1'b0, BUB, "rst0");
    step(1'b0, A,      LW3,    1'b0, 1'b0, mk(1'b1, A, 5'd3, 32'h0, 7'b1101000), "lw3_a");
    step(1'b0, A+4,    ADD5,   1'b0, 1'b1, BUB, "add_stall_a");
    step(1'b1, 32'h0,  32'h0,  1'b0, 1'b0, BUB, "rst_hold");
    step(1'b0, 32'h0,  32'h0,  1'b0, 1'b0, BUB, "after_rst");
    step(1'b0, A,      ADDIU5, 1'b0, 1'b0, mk(1'b1, A, 5'd2, 32'h5, 7'b1001000), "addiu5");
    // Immediate extension and JAL
    step(1'b0, A+4,    ANDI,   1'b0, 1'b0, mk(1'b1, A+4, 5'd2, 32'h0000FFFF, 7'b1001000), "andi");
    step(1'b0, A+8,    ADDIUM, 1'b0, 1'b0, mk(1'b1, A+8, 5'd2, 32'hFFFFFFFF, 7'b1001000), "addiu_m1");
    step(1'b0, A+12,   JAL,    1'b0, 1'b0, mk(1'b1, A+12, 5'd31, 32'h10, 7'b1000010), "jal");
    // Load-use on rs: one bubble then replay from hold
    step(1'b0, A,      LW3,    1'b0, 1'b0, mk(1'b1, A, 5'd3, 32'h0, 7'b1101000), "lw3_b");
    step(1'b0, A+4,    ADD5,   1'b0, 1'b1, BUB, "add_stall_b");
    step(1'b0, 32'h0,  32'h0,  1'b0, 1'b0, mk(1'b1, A+4, 5'd5, 32'h2820, 7'b1000000), "add_replay");
    step(1'b0, A+8,    ADDIU5, 1'b0, 1'b0, mk(1'b1, A+8, 5'd2, 32'h5, 7'b1001000), "addiu_next");
    // Load-use on rt (SW), no use (LUI), load to $0
    step(1'b0, A,      LW3,    1'b0, 1'b0, mk(1'b1, A, 5'd3, 32'h0, 7'b1101000), "lw3_c");
    step(1'b0, A+4,    SW3,    1'b0, 1'b1, BUB, "sw_stall");
    step(1'b0, 32'h0,  32'h0,  1'b0, 1'b0, mk(1'b1, A+4, 5'd0, 32'h0, 7'b0011000), "sw_replay");
    step(1'b0, A+8,    LW3,    1'b0, 1'b0, mk(1'b1, A+8, 5'd3, 32'h0, 7'b1101000), "lw3_d");
    step(1'b0, A+12,   LUI3,   1'b0, 1'b0, mk(1'b1, A+12, 5'd3, 32'h1, 7'b1001000), "lui_nostall");
    step(1'b0, A+16,   LW0,    1'b0, 1'b0, mk(1'b1, A+16, 5'd0, 32'h0, 7'b0101000), "lw0");
    step(1'b0, A+20,   ADDZ,   1'b0, 1'b0, mk(1'b1, A+20, 5'd5, 32'h2820, 7'b1000000), "add_r0");
    // LW -> dependent LW -> use: two independent stalls
    step(1'b0, A,      LW3,    1'b0, 1'b0, mk(1'b1, A, 5'd3, 32'h0, 7'b1101000), "lw3_e");
    step(1'b0, A+4,    LW4,    1'b0, 1'b1, BUB, "lw4_stall");
    step(1'b0, 32'h0,  32'h0,  1'b0, 1'b0, mk(1'b1, A+4, 5'd4, 32'h0, 7'b1101000), "lw4_replay");
    step(1'b0, A+8,    ADD5B,  1'b0, 1'b1, BUB, "add4_stall");
    step(1'b0, 32'h0,  32'h0,  1'b0, 1'b0, mk(1'b1, A+8, 5'd5, 32'h2820, 7'b1000000), "add4_replay");
    // Flush beats hazard, and discards a held instruction
    step(1'b0, A,      LW3,    1'b0, 1'b0, mk(1'b1, A, 5'd3, 32'h0, 7'b1101000), "lw3_f");
    step(1'b0, A+4,    ADD5,   1'b1, 1'b0, BUB, "flush_hazard");
    step(1'b0, 32'h0,  32'h0,  1'b0, 1'b0, BUB, "no_hold");
    step(1'b0, A,      LW3,    1'b0, 1'b0, mk(1'b1, A, 5'd3, 32'h0, 7'b1101000), "lw3_g");
    step(1'b0, A+4,    ADD5,   1'b0, 1'b1, BUB, "add_stall_g");
    step(1'b0, 32'h0,  32'h0,  1'b1, 1'b0, BUB, "flush_held");
    step(1'b0, 32'h0,  32'h0,  1'b0, 1'b0, BUB, "held_gone");
    step(1'b0, A,      ADDIU5, 1'b1, 1'b0, BUB, "flush_real");
    // Illegal opcode for one cycle, then a bubble
    step(1'b0, A,      ILL,    1'b0, 1'b0, mk(1'b1, A, 5'd0, 32'h0, 7'b0000001), "illegal");
    step(1'b0, 32'h0,  32'h0,  1'b0, 1'b0, BUB, "nop_pc");
    step(1'b0, A+4,    ADDIU5, 1'b0, 1'b0, mk(1'b1, A+4, 5'd2, 32'h5, 7'b1001000), "addiu_end");
    @(posedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
